// File: rtl/calc_controller.sv
// Two-operand single-digit calculator front end: debounced buttons, entry/result FSM
// driving an external 4-bit adder-subtractor, and a multiplexed 4-digit BCD display.
module calc_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_DIV        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       btn_op,
    input  logic       btn_eq,
    input  logic       btn_clr,
    input  logic [3:0] alu_s,
    input  logic       alu_co,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic       sub,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [3:0] an_n,
    output logic [3:0] seg_code,
    output logic [1:0] state_o
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {ENTRY = 2'd0, SETTLE = 2'd1, RESULT = 2'd2} state_t;

    logic [4:0] btn_raw;
    logic [4:0] press;
    logic [1:0] start_reg;

    assign btn_raw = {btn_clr, btn_eq, btn_op, btn_b, btn_a};

    // A button may only arm once the synchronizer holds a real post-reset sample,
    // so a button held through reset stays disarmed until it is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) start_reg <= 2'b00;
        else        start_reg <= {start_reg[0], 1'b1};
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_btn
            logic            sync1_reg, sync2_reg, armed_reg, pulse_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    armed_reg <= 1'b0;
                    pulse_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    pulse_reg <= 1'b0;
                    if (!sync2_reg) begin
                        cnt_reg <= '0;
                        if (start_reg[1]) armed_reg <= 1'b1;
                    end else if (armed_reg) begin
                        if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                            pulse_reg <= 1'b1;
                            armed_reg <= 1'b0;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
            end

            assign press[gi] = pulse_reg;
        end
    endgenerate

    logic a_p, b_p, op_p, eq_p, clr_p;
    assign {clr_p, eq_p, op_p, b_p, a_p} = press;

    state_t     state_reg, state_next;
    logic [3:0] op_a_reg, op_b_reg, tens_reg, ones_reg;
    logic       sub_reg;
    logic [3:0] fmt_tens, fmt_ones;
    logic [4:0] add_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ENTRY;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (clr_p) begin
            state_next = ENTRY;
        end else begin
            case (state_reg)
                ENTRY:   if (eq_p) state_next = SETTLE;
                SETTLE:  state_next = RESULT;
                RESULT:  if (eq_p) state_next = ENTRY;
                default: state_next = ENTRY;
            endcase
        end
    end

    // SETTLE gives the external ripple adder a full cycle before its result is captured.
    assign add_v = {alu_co, alu_s};
    always_comb begin
        fmt_tens = 4'd0;
        fmt_ones = alu_s;
        if (!sub_reg) begin
            if (add_v > 5'd9) begin
                fmt_tens = 4'd1;
                fmt_ones = 4'(add_v - 5'd10);
            end
        end else if (!alu_co) begin
            fmt_tens = 4'd10;
            fmt_ones = ~alu_s + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_reg <= 4'd0;
            op_b_reg <= 4'd0;
            sub_reg  <= 1'b0;
            tens_reg <= 4'd0;
            ones_reg <= 4'd0;
        end else if (clr_p) begin
            op_a_reg <= 4'd0;
            op_b_reg <= 4'd0;
            sub_reg  <= 1'b0;
            tens_reg <= 4'd0;
            ones_reg <= 4'd0;
        end else begin
            case (state_reg)
                ENTRY: if (!eq_p) begin
                    if (a_p)  op_a_reg <= (op_a_reg == 4'd9) ? 4'd0 : op_a_reg + 4'd1;
                    if (b_p)  op_b_reg <= (op_b_reg == 4'd9) ? 4'd0 : op_b_reg + 4'd1;
                    if (op_p) sub_reg  <= ~sub_reg;
                end
                SETTLE: begin
                    tens_reg <= fmt_tens;
                    ones_reg <= fmt_ones;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if (state_reg == RESULT) begin
            dig0 = 4'd0;
            dig1 = 4'd0;
            dig2 = tens_reg;
            dig3 = ones_reg;
        end else begin
            dig0 = op_a_reg;
            dig1 = op_b_reg;
            dig2 = 4'd0;
            dig3 = 4'd0;
        end
    end

    assign op_a    = op_a_reg;
    assign op_b    = op_b_reg;
    assign sub     = sub_reg;
    assign state_o = state_reg;

    logic [SC_W-1:0] scan_cnt_reg;
    logic [1:0]      scan_idx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_reg <= '0;
            scan_idx_reg <= 2'd0;
        end else if (scan_cnt_reg == SC_W'(SCAN_DIV - 1)) begin
            scan_cnt_reg <= '0;
            scan_idx_reg <= scan_idx_reg + 2'd1;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
        end
    end

    assign an_n = ~(4'b0001 << scan_idx_reg);

    always_comb begin
        case (scan_idx_reg)
            2'd0:    seg_code = dig0;
            2'd1:    seg_code = dig1;
            2'd2:    seg_code = dig2;
            default: seg_code = dig3;
        endcase
    end
endmodule
